// File: rtl/mov_pkg.sv
// Shared opcode and control-state encodings for the register-move unit.
package mov_pkg;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_MOV  = 2'd1;
    localparam logic [1:0] OP_MOVI = 2'd2;
    localparam logic [1:0] OP_SWAP = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWAP2 = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

endpackage

// File: rtl/mov_regfile_if.sv
// Command handshake, read port and completion signals of the register-move unit.
interface mov_regfile_if #(
    parameter int unsigned N = 4,
    parameter int unsigned R = 4
);
    localparam int unsigned AW = (R > 1) ? $clog2(R) : 1;

    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [N-1:0]  imm;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;
    logic          done;
    logic          eq_flag;

    modport master (
        output in_valid, op, rd, rs, imm, rd_addr,
        input  in_ready, rd_data, done, eq_flag
    );

    modport slave (
        input  in_valid, op, rd, rs, imm, rd_addr,
        output in_ready, rd_data, done, eq_flag
    );

endinterface

// File: rtl/mov_regbank.sv
// R x N register storage: one synchronous write port, combinational read ports.
// Out-of-range addresses drop writes and read as zero.
module mov_regbank #(
    parameter int unsigned N  = 4,
    parameter int unsigned R  = 4,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] a_addr,
    output logic [N-1:0]  a_data,
    input  logic [AW-1:0] b_addr,
    output logic [N-1:0]  b_data,
    input  logic [AW-1:0] c_addr,
    output logic [N-1:0]  c_data
);

    logic [N-1:0] mem [R];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(R); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (32'(waddr) < R)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        a_data = '0;
        b_data = '0;
        c_data = '0;
        if (32'(a_addr) < R) a_data = mem[a_addr];
        if (32'(b_addr) < R) b_data = mem[b_addr];
        if (32'(c_addr) < R) c_data = mem[c_addr];
    end

endmodule

// File: rtl/mov_regfile.sv
// Register-move unit: executes NOP/MOV/MOVI/SWAP commands over a valid/ready
// handshake and self-checks the destination during a one-cycle done pulse.
module mov_regfile
    import mov_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned R = 4
) (
    input logic          clk,
    input logic          rst,
    mov_regfile_if.slave bus
);

    localparam int unsigned AW = (R > 1) ? $clog2(R) : 1;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  temp_q, expect_q;
    logic [1:0]    op_q;
    logic [AW-1:0] rd_q, rs_q;
    logic          bad_q;

    logic          fire;
    logic          we;
    logic [AW-1:0] waddr, a_addr, b_addr;
    logic [N-1:0]  wdata, a_data, b_data;
    logic          chk;
    logic          bad_d;

    assign bus.in_ready = (state_q == S_IDLE) && !rst;
    assign fire         = bus.in_valid && bus.in_ready;

    // Port A follows rd, port B follows rs: live command in IDLE, latched ones after.
    assign a_addr = (state_q == S_IDLE) ? bus.rd : rd_q;
    assign b_addr = (state_q == S_IDLE) ? bus.rs : rs_q;

    mov_regbank #(
        .N  (N),
        .R  (R),
        .AW (AW)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .a_addr (a_addr),
        .a_data (a_data),
        .b_addr (b_addr),
        .b_data (b_data),
        .c_addr (bus.rd_addr),
        .c_data (bus.rd_data)
    );

    always_comb begin
        bad_d = (32'(bus.rd) >= R);
        if ((bus.op == OP_MOV) || (bus.op == OP_SWAP)) begin
            bad_d = bad_d || (32'(bus.rs) >= R);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fire) state_d = (bus.op == OP_SWAP) ? S_SWAP2 : S_CHECK;
            S_SWAP2: state_d = S_CHECK;
            S_CHECK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        we    = 1'b0;
        waddr = bus.rd;
        wdata = b_data;
        if (fire) begin
            case (bus.op)
                OP_MOV:  we = 1'b1;
                OP_MOVI: begin
                    we    = 1'b1;
                    wdata = bus.imm;
                end
                OP_SWAP: we = 1'b1;
                default: we = 1'b0;
            endcase
        end else if (state_q == S_SWAP2) begin
            we    = 1'b1;
            waddr = rs_q;
            wdata = temp_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            temp_q   <= '0;
            expect_q <= '0;
            op_q     <= OP_NOP;
            rd_q     <= '0;
            rs_q     <= '0;
            bad_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                op_q     <= bus.op;
                rd_q     <= bus.rd;
                rs_q     <= bus.rs;
                bad_q    <= bad_d;
                expect_q <= (bus.op == OP_MOVI) ? bus.imm : b_data;
                if (bus.op == OP_SWAP) temp_q <= a_data;
            end
        end
    end

    always_comb begin
        chk = 1'b0;
        case (op_q)
            OP_NOP:  chk = 1'b1;
            OP_MOV,
            OP_MOVI: chk = (a_data == expect_q) && !bad_q;
            OP_SWAP: chk = (a_data == expect_q) && (b_data == temp_q) && !bad_q;
            default: chk = 1'b0;
        endcase
    end

    assign bus.done    = (state_q == S_CHECK);
    assign bus.eq_flag = bus.done && chk;

endmodule
